// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the write-back queue entry type.
package mips_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_buffer_if.sv
// Write-back request, RF write port and forwarding lookup bundle for writeback_buffer.
interface writeback_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              rf_hold;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] fwd_addr1;
  logic [ADDR_W-1:0] fwd_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output in_valid, in_addr, in_data, rf_hold, fwd_addr1, fwd_addr2,
    input  in_ready, rf_we, rf_addr, rf_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, rf_hold, fwd_addr1, fwd_addr2,
    output in_ready, rf_we, rf_addr, rf_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
  );
endinterface

// File: rtl/writeback_buffer_fwd_match.sv
// Youngest-match lookup of one read operand against the pending write-back entries.
// Only built when WB_FORWARD_EN is defined.
`ifdef WB_FORWARD_EN
module wb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]         entries,
  input  logic [$clog2(DEPTH)-1:0]      wr_ptr,
  input  logic [ADDR_W-1:0]             addr,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Slot wr_ptr is the oldest, wr_ptr-1 the youngest; scanning upward lets the last match win.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wr_ptr + PTR_W'(i);
      if (entries[idx].valid && entries[idx].addr == addr && addr != REG_ZERO) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule
`endif

// File: rtl/writeback_buffer.sv
// FIFO of RF write-backs drained one per cycle onto the single RF write port; drops writes to $0.
// Define WB_FORWARD_EN to forward pending data to the two ID-stage read operands.
module writeback_buffer
  import mips_pkg::wb_entry_t, mips_pkg::REG_ZERO;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input logic              clk,
  input logic              rst,
  writeback_buffer_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_LK = 2;

  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, accept, keep, drain;
  wb_entry_t             head;

  assign full   = (count == CNT_W'(DEPTH));
  assign accept = wb.in_valid && !full;
  assign keep   = accept && (wb.in_addr != REG_ZERO);
  assign drain  = (count != '0) && !wb.rf_hold;
  assign head   = entries[rd_ptr];

  assign wb.in_ready = !full;
  assign wb.rf_we    = drain;
  assign wb.rf_addr  = (count != '0) ? head.addr : '0;
  assign wb.rf_data  = (count != '0) ? head.data : '0;
  assign wb.count    = count;

  // Full and empty never coincide, so a same-cycle write and drain always touch different slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (drain) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= rd_ptr + 1'b1;
      end
      if (keep) begin
        entries[wr_ptr] <= '{valid: 1'b1, addr: wb.in_addr, data: wb.in_data};
        wr_ptr          <= wr_ptr + 1'b1;
      end
      unique case ({keep, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  logic [NUM_LK-1:0][ADDR_W-1:0] lk_addr;
  logic [NUM_LK-1:0]             lk_hit;
  logic [NUM_LK-1:0][DATA_W-1:0] lk_data;

  assign lk_addr = {wb.fwd_addr2, wb.fwd_addr1};

  for (genvar p = 0; p < NUM_LK; p++) begin : g_lk
    wb_fwd_match #(.DEPTH(DEPTH)) u_match (
      .entries (entries),
      .wr_ptr  (wr_ptr),
      .addr    (lk_addr[p]),
      .hit     (lk_hit[p]),
      .data    (lk_data[p])
    );
  end

  assign wb.fwd_hit1  = lk_hit[0];
  assign wb.fwd_hit2  = lk_hit[1];
  assign wb.fwd_data1 = lk_data[0];
  assign wb.fwd_data2 = lk_data[1];
`else
  assign wb.fwd_hit1  = 1'b0;
  assign wb.fwd_hit2  = 1'b0;
  assign wb.fwd_data1 = '0;
  assign wb.fwd_data2 = '0;
`endif
endmodule
